ctrl_cmd_sender: RTL and testbench

//  Initiator end of the controller byte protocol. Accepts one whole command per handshake and serialises it MSB-first
//  as opcode + operand bytes onto the out_byte/out_valid lines, pacing each byte on the receiver's `next` acknowledge.

---
 rtl/ctrl_cmd_sender_pkg.sv | 40 ++++
 rtl/ctrl_cmd_classify.sv | 50 +++++
 rtl/ctrl_cmd_sender.sv | 193 +++++++++++++++++++
 tb/tb_ctrl_cmd_sender.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_cmd_sender_pkg.sv
// Shared definitions for the controller command sender.
//  - Opcodes of the controller byte protocol. Bit 3 is the pipeline-select bit and is
//    carried through in the byte that goes out, but it plays no part in classification.
//  - Field-mask bits that describe which operand fields follow the opcode byte.
//  - Sender FSM state encodings.
package ctrl_cmd_sender_pkg;

  localparam int BLOCK_INSTR_WIDTH    = 32;
  localparam int BLOCK_REG_ADDR_WIDTH = 4;
  localparam int BYTE_CNT_W           = 6;

  localparam logic [7:0] OPC_PIPE_SEL               = 8'h08;
  localparam logic [7:0] COMMAND_WRITE_BLOCK_INSTR  = 8'h01;
  localparam logic [7:0] COMMAND_WRITE_BLOCK_REG    = 8'h02;
  localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG   = 8'h03;
  localparam logic [7:0] COMMAND_ALLOC_DELAY        = 8'h04;
  localparam logic [7:0] COMMAND_SET_INPUT_GAIN     = 8'h05;
  localparam logic [7:0] COMMAND_SET_OUTPUT_GAIN    = 8'h06;
  localparam logic [7:0] COMMAND_COMMIT_REG_UPDATES = 8'h10;
  localparam logic [7:0] COMMAND_SWAP_PIPELINES     = 8'h11;
  localparam logic [7:0] COMMAND_RESET_PIPELINE     = 8'h12;

  // Operand fields present in a frame, in wire order after the opcode byte.
  typedef struct packed {
    logic has_block;
    logic has_reg;
    logic has_data;
    logic has_instr;
    logic has_delay;
  } frame_mask_t;

  typedef enum logic [2:0] {
    CMD_SENDER_STATE_IDLE = 3'd0,
    CMD_SENDER_STATE_LOAD = 3'd1,
    CMD_SENDER_STATE_SEND = 3'd2,
    CMD_SENDER_STATE_GAP  = 3'd3,
    CMD_SENDER_STATE_DONE = 3'd4
  } cmd_sender_state_t;

endpackage

// File: rtl/ctrl_cmd_classify.sv
// Opcode classifier (purely combinational).
// Ports:
//  opcode   in   8           full opcode byte (pipeline-select bit ignored)
//  mask     out  frame_mask  operand fields that follow the opcode
//  n_bytes  out  6           total frame length in bytes, opcode included
//  invalid  out  1           opcode not recognised; nothing is to be sent
module ctrl_cmd_classify
  import ctrl_cmd_sender_pkg::*;
#(
  parameter int data_width  = 16,
  parameter int instr_width = BLOCK_INSTR_WIDTH
) (
  input  logic [7:0]            opcode,
  output frame_mask_t           mask,
  output logic [BYTE_CNT_W-1:0] n_bytes,
  output logic                  invalid
);

  logic [7:0] base;
  assign base = opcode & ~OPC_PIPE_SEL;

  always_comb begin
    mask    = '0;
    invalid = 1'b0;
    case (base)
      COMMAND_WRITE_BLOCK_INSTR: begin
        mask.has_block = 1'b1;
        mask.has_instr = 1'b1;
      end
      COMMAND_WRITE_BLOCK_REG, COMMAND_UPDATE_BLOCK_REG: begin
        mask.has_block = 1'b1;
        mask.has_reg   = 1'b1;
        mask.has_data  = 1'b1;
      end
      COMMAND_ALLOC_DELAY: begin
        mask.has_data  = 1'b1;
        mask.has_delay = 1'b1;
      end
      COMMAND_SET_INPUT_GAIN, COMMAND_SET_OUTPUT_GAIN: mask.has_data = 1'b1;
      COMMAND_COMMIT_REG_UPDATES, COMMAND_SWAP_PIPELINES, COMMAND_RESET_PIPELINE: ;
      default: invalid = 1'b1;
    endcase
  end

  assign n_bytes = BYTE_CNT_W'(1 + (mask.has_block ? 1 : 0) + (mask.has_reg ? 1 : 0)
                   + (mask.has_data  ? data_width/8  : 0)
                   + (mask.has_instr ? instr_width/8 : 0)
                   + (mask.has_delay ? 4 : 0));

endmodule

// File: rtl/ctrl_cmd_sender.sv
// Initiator end of the controller byte protocol: takes one whole command per
// cmd_valid/cmd_ready handshake and serialises it MSB-first as opcode + operand
// bytes on out_byte/out_valid, one byte per out_next acknowledge.
// Ports:
//  clk, reset_n             clock, asynchronous active-low reset
//  cmd_valid / cmd_ready    command handshake (ready only in IDLE)
//  cmd_opcode .. cmd_delay  command fields, latched on accept
//  out_byte / out_valid     byte to receiver, held until out_next
//  out_next                 receiver consumed the byte
//  cmd_done                 1-cycle pulse once the frame is complete
//  cmd_error                1-cycle pulse: unknown opcode, nothing sent
//  cmd_timeout              1-cycle pulse: frame abandoned on ack timeout
// Build option: CTRL_CMD_SENDER_TIMEOUT_EN enables the ack timeout; otherwise
// the sender waits for out_next indefinitely and cmd_timeout is tied low.
module ctrl_cmd_sender
  import ctrl_cmd_sender_pkg::*;
#(
  parameter int data_width     = 16,
  parameter int instr_width    = BLOCK_INSTR_WIDTH,
  parameter int n_blocks       = 256,
  parameter int inter_byte_gap = 2,
  parameter int timeout_cycles = 65535
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [7:0]                      cmd_opcode,
  input  logic [$clog2(n_blocks)-1:0]     cmd_block,
  input  logic [BLOCK_REG_ADDR_WIDTH-1:0] cmd_reg,
  input  logic [data_width-1:0]           cmd_data,
  input  logic [instr_width-1:0]          cmd_instr,
  input  logic [31:0]                     cmd_delay,
  output logic [7:0]                      out_byte,
  output logic                            out_valid,
  input  logic                            out_next,
  output logic                            cmd_done,
  output logic                            cmd_error,
  output logic                            cmd_timeout
);

  localparam int BW        = $clog2(n_blocks);
  localparam int F_INSTR   = 2 + instr_width/8;
  localparam int F_REG     = 3 + data_width/8;
  localparam int F_DLY     = 5 + data_width/8;
  localparam int MAX_A     = (F_INSTR > F_REG) ? F_INSTR : F_REG;
  localparam int MAX_BYTES = (MAX_A > F_DLY) ? MAX_A : F_DLY;
  localparam int SR_W      = 8 * MAX_BYTES;
  localparam int GAP_W     = $clog2(inter_byte_gap + 1);

  cmd_sender_state_t state_q, state_d;

  logic [7:0]                      opc_q;
  logic [BW-1:0]                   blk_q;
  logic [BLOCK_REG_ADDR_WIDTH-1:0] reg_q;
  logic [data_width-1:0]           data_q;
  logic [instr_width-1:0]          instr_q;
  logic [31:0]                     delay_q;

  logic [SR_W-1:0]       sr_q, acc, frame;
  logic [BYTE_CNT_W-1:0] bytes_left, n_bytes;
  logic [GAP_W-1:0]      gap_cnt;
  frame_mask_t           mask;
  logic                  invalid, ack, to_fire;

  ctrl_cmd_classify #(.data_width(data_width), .instr_width(instr_width)) u_classify (
    .opcode (opc_q),
    .mask   (mask),
    .n_bytes(n_bytes),
    .invalid(invalid)
  );

  // Append present fields in wire order, then left-align so the opcode sits in
  // the top byte of the shift register.
  always_comb begin
    acc = SR_W'(opc_q);
    if (mask.has_block) acc = (acc << 8)           | SR_W'(8'(blk_q));
    if (mask.has_reg)   acc = (acc << 8)           | SR_W'(8'(reg_q));
    if (mask.has_data)  acc = (acc << data_width)  | SR_W'(data_q);
    if (mask.has_instr) acc = (acc << instr_width) | SR_W'(instr_q);
    if (mask.has_delay) acc = (acc << 32)          | SR_W'(delay_q);
    frame = acc << (8 * (MAX_BYTES - int'(n_bytes)));
  end

  assign ack      = (state_q == CMD_SENDER_STATE_SEND) && out_next;
  assign out_byte = sr_q[SR_W-1 -: 8];

`ifdef CTRL_CMD_SENDER_TIMEOUT_EN
  localparam int TO_W = $clog2(timeout_cycles + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit, timeout_q;

  // to_cnt holds the number of completed unacked SEND cycles, so the hit
  // fires on the timeout_cycles-th cycle that out_valid is high.
  assign to_hit      = (to_cnt == TO_W'(timeout_cycles - 1));
  assign cmd_timeout = timeout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_fire;
      if (state_q == CMD_SENDER_STATE_SEND && !out_next && !to_hit) to_cnt <= to_cnt + 1'b1;
      else                                                           to_cnt <= '0;
    end
  end
`else
  assign cmd_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    out_valid = 1'b0;
    cmd_done  = 1'b0;
    cmd_error = 1'b0;
    to_fire   = 1'b0;
    case (state_q)
      CMD_SENDER_STATE_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = CMD_SENDER_STATE_LOAD;
      end
      CMD_SENDER_STATE_LOAD: begin
        if (invalid) begin
          cmd_error = 1'b1;
          state_d   = CMD_SENDER_STATE_IDLE;
        end else begin
          state_d = CMD_SENDER_STATE_SEND;
        end
      end
      CMD_SENDER_STATE_SEND: begin
        out_valid = 1'b1;
        if (out_next) state_d = CMD_SENDER_STATE_GAP;
`ifdef CTRL_CMD_SENDER_TIMEOUT_EN
        else if (to_hit) begin
          to_fire = 1'b1;
          state_d = CMD_SENDER_STATE_IDLE;
        end
`endif
      end
      CMD_SENDER_STATE_GAP: begin
        if (gap_cnt == '0)
          state_d = (bytes_left == '0) ? CMD_SENDER_STATE_DONE : CMD_SENDER_STATE_SEND;
      end
      CMD_SENDER_STATE_DONE: begin
        cmd_done = 1'b1;
        state_d  = CMD_SENDER_STATE_IDLE;
      end
      default: state_d = CMD_SENDER_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= CMD_SENDER_STATE_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opc_q      <= '0;
      blk_q      <= '0;
      reg_q      <= '0;
      data_q     <= '0;
      instr_q    <= '0;
      delay_q    <= '0;
      sr_q       <= '0;
      bytes_left <= '0;
      gap_cnt    <= '0;
    end else begin
      if (cmd_ready && cmd_valid) begin
        opc_q   <= cmd_opcode;
        blk_q   <= cmd_block;
        reg_q   <= cmd_reg;
        data_q  <= cmd_data;
        instr_q <= cmd_instr;
        delay_q <= cmd_delay;
      end
      if (state_q == CMD_SENDER_STATE_LOAD) begin
        sr_q       <= frame;
        bytes_left <= n_bytes;
      end
      if (ack) begin
        sr_q       <= sr_q << 8;
        bytes_left <= bytes_left - 1'b1;
        gap_cnt    <= GAP_W'(inter_byte_gap - 1);
      end else if (state_q == CMD_SENDER_STATE_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_cmd_sender.sv
module tb_ctrl_cmd_sender;

  localparam int GAP = 2;
  localparam int TO  = 100;

  logic        clk, reset_n;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_opcode, cmd_block;
  logic [3:0]  cmd_reg;
  logic [15:0] cmd_data;
  logic [31:0] cmd_instr, cmd_delay;
  logic [7:0]  out_byte;
  logic        out_valid, out_next;
  logic        cmd_done, cmd_error, cmd_timeout;

  int checks = 0, errors = 0;
  int done_seen = 0, err_seen = 0, to_seen = 0;
  int exp_done = 0, exp_err = 0;

  ctrl_cmd_sender #(
    .data_width(16), .instr_width(32), .n_blocks(256),
    .inter_byte_gap(GAP), .timeout_cycles(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_block(cmd_block), .cmd_reg(cmd_reg),
    .cmd_data(cmd_data), .cmd_instr(cmd_instr), .cmd_delay(cmd_delay),
    .out_byte(out_byte), .out_valid(out_valid), .out_next(out_next),
    .cmd_done(cmd_done), .cmd_error(cmd_error), .cmd_timeout(cmd_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_done)    done_seen++;
    if (cmd_error)   err_seen++;
    if (cmd_timeout) to_seen++;
  end

  typedef struct {
    logic [7:0]      opc;
    logic [7:0]      blk;
    logic [3:0]      rg;
    logic [15:0]     data;
    logic [31:0]     instr;
    logic [31:0]     dly;
    int              n;
    logic [0:7][7:0] b;
    bit              err;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Present a command and return at the negedge of the cycle after accept (LOAD).
  task automatic send_cmd(input logic [7:0] opc, input logic [7:0] blk, input logic [3:0] rg,
                          input logic [15:0] data, input logic [31:0] instr, input logic [31:0] dly,
                          input bit release_valid);
    int w = 0;
    cmd_opcode = opc; cmd_block = blk; cmd_reg = rg;
    cmd_data = data; cmd_instr = instr; cmd_delay = dly;
    cmd_valid = 1'b1;
    while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
    chk("accept_wait", cmd_ready, 1);
    @(negedge clk);
    if (release_valid) cmd_valid = 1'b0;
    // Fields are latched; scrambling them must not affect the frame.
    cmd_opcode = ~opc; cmd_block = ~blk; cmd_reg = ~rg;
    cmd_data = ~data; cmd_instr = ~instr; cmd_delay = ~dly;
    chk("load_ready", cmd_ready, 0);
    chk("load_valid", out_valid, 0);
  endtask

  // Receiver model: checks each byte, holds for a varying number of cycles,
  // acks, and checks the gap and the completion timing.
  task automatic recv_frame(input logic [0:7][7:0] b, input int n, input bit stray, input bit fin);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!out_valid && w < 40) begin @(negedge clk); out_next = 1'b0; w++; end
      chk("byte_valid", out_valid, 1);
      if (!out_valid) return;
      if (i == 0) chk("first_lat", w, 1);
      else        chk("gap_len", w, GAP);
      chk("byte", out_byte, b[i]);
      repeat (i % 3) begin
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_byte", out_byte, b[i]);
      end
      out_next = 1'b1;
      @(negedge clk);
      out_next = stray && (i == 0);  // stray pulse while out_valid is low
      chk("drop_after_ack", out_valid, 0);
    end
    if (fin) begin
      int w = 0;
      while (!cmd_done && w < 20) begin @(negedge clk); out_next = 1'b0; w++; end
      chk("done_lat", w, GAP);
      chk("done_busy", cmd_ready, 0);
      exp_done++;
      @(negedge clk);
      chk("done_pulse", cmd_done, 0);
      chk("ready_back", cmd_ready, 1);
    end
    out_next = 1'b0;
  endtask

  initial begin
    int w, cnt;
    vt[0]  = '{8'h02, 8'h05, 4'h1, 16'h1234, 32'hCAFEF00D, 32'h5555AAAA, 5, 64'h0205_0112_3400_0000, 1'b0};
    vt[1]  = '{8'h04, 8'h33, 4'h7, 16'h0010, 32'h11111111, 32'h0001E240, 7, 64'h0400_1000_01E2_4000, 1'b0};
    vt[2]  = '{8'h09, 8'h07, 4'h3, 16'h9999, 32'hDEADBEEF, 32'h0,        6, 64'h0907_DEAD_BEEF_0000, 1'b0};
    vt[3]  = '{8'h03, 8'hA0, 4'hF, 16'hBEEF, 32'h0,        32'h0,        5, 64'h03A0_0FBE_EF00_0000, 1'b0};
    vt[4]  = '{8'h05, 8'h44, 4'h2, 16'h7FFF, 32'h0,        32'h0,        3, 64'h057F_FF00_0000_0000, 1'b0};
    vt[5]  = '{8'h0E, 8'h44, 4'h2, 16'h8001, 32'h0,        32'h0,        3, 64'h0E80_0100_0000_0000, 1'b0};
    vt[6]  = '{8'h10, 8'h12, 4'h4, 16'h5678, 32'h9,        32'h9,        1, 64'h1000_0000_0000_0000, 1'b0};
    vt[7]  = '{8'h1A, 8'h12, 4'h4, 16'h5678, 32'h9,        32'h9,        1, 64'h1A00_0000_0000_0000, 1'b0};
    vt[8]  = '{8'hFF, 8'h01, 4'h1, 16'h1,    32'h1,        32'h1,        0, 64'h0,                   1'b1};
    vt[9]  = '{8'h00, 8'h01, 4'h1, 16'h1,    32'h1,        32'h1,        0, 64'h0,                   1'b1};
    vt[10] = '{8'h07, 8'h01, 4'h1, 16'h1,    32'h1,        32'h1,        0, 64'h0,                   1'b1};

    reset_n = 1'b0; cmd_valid = 1'b0; out_next = 1'b0;
    cmd_opcode = '0; cmd_block = '0; cmd_reg = '0; cmd_data = '0; cmd_instr = '0; cmd_delay = '0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_error", cmd_error, 0);
    chk("rst_timeout", cmd_timeout, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);

    for (int k = 0; k < NV; k++) begin
      send_cmd(vt[k].opc, vt[k].blk, vt[k].rg, vt[k].data, vt[k].instr, vt[k].dly, 1'b1);
      if (vt[k].err) begin
        chk("err_pulse", cmd_error, 1);
        chk("err_novalid", out_valid, 0);
        exp_err++;
        @(negedge clk);
        chk("err_once", cmd_error, 0);
        chk("err_ready", cmd_ready, 1);
        chk("err_novalid2", out_valid, 0);
      end else begin
        recv_frame(vt[k].b, vt[k].n, (k % 2) == 1, 1'b1);
      end
      @(negedge clk);
    end

    // Back-to-back: cmd_valid stays high across the first frame.
    send_cmd(8'h11, 8'h00, 4'h0, 16'h0, 32'h0, 32'h0, 1'b0);
    cmd_opcode = 8'h01; cmd_block = 8'h07; cmd_instr = 32'h0BADF00D;
    cmd_reg = 4'h0; cmd_data = 16'h0; cmd_delay = 32'h0;
    recv_frame(64'h1100_0000_0000_0000, 1, 1'b0, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_load", cmd_ready, 0);
    recv_frame(64'h0107_0BAD_F00D_0000, 6, 1'b0, 1'b1);

    // Reset in the middle of a frame, on the third byte.
    @(negedge clk);
    send_cmd(8'h02, 8'h05, 4'h1, 16'h1234, 32'h0, 32'h0, 1'b1);
    recv_frame(64'h0205_0112_3400_0000, 2, 1'b0, 1'b0);
    w = 0;
    while (!out_valid && w < 40) begin @(negedge clk); w++; end
    chk("third_valid", out_valid, 1);
    chk("third_byte", out_byte, 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_byte", out_byte, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", cmd_ready, 1);
    send_cmd(8'h02, 8'h05, 4'h1, 16'h1234, 32'h0, 32'h0, 1'b1);
    recv_frame(64'h0205_0112_3400_0000, 5, 1'b0, 1'b1);

    // Receiver withholds out_next.
    @(negedge clk);
`ifdef CTRL_CMD_SENDER_TIMEOUT_EN
    send_cmd(8'h05, 8'h00, 4'h0, 16'h00AA, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("to_valid", out_valid, 1);
    cnt = 0;
    while (out_valid && cnt < 300) begin cnt++; @(negedge clk); end
    chk("to_len", cnt, TO);
    chk("to_pulse", cmd_timeout, 1);
    chk("to_ready", cmd_ready, 1);
    @(negedge clk);
    chk("to_once", cmd_timeout, 0);
    chk("to_count", to_seen, 1);
`else
    send_cmd(8'h10, 8'h00, 4'h0, 16'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    cnt = 0;
    while (out_valid && cnt < 150) begin cnt++; @(negedge clk); end
    chk("stall_len", cnt, 150);
    chk("stall_valid", out_valid, 1);
    chk("stall_byte", out_byte, 8'h10);
    out_next = 1'b1;
    @(negedge clk);
    out_next = 1'b0;
    chk("stall_drop", out_valid, 0);
    @(negedge clk); @(negedge clk);
    chk("stall_done", cmd_done, 1);
    exp_done++;
    chk("to_count", to_seen, 0);
`endif

    @(negedge clk);
    chk("done_count", done_seen, exp_done);
    chk("err_count", err_seen, exp_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

endmodule
